// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR flip-flop command generator.
// Holds the FSM state encoding, the default bank width and pulse length,
// the pulse-counter width, and a helper that clamps a pulse length into
// the range the counter can represent.
package sr_cmd_pkg;

    // Default number of SR flops in the bank.
    localparam int DEF_WIDTH        = 8;

    // Default number of cycles s/r stay asserted per update.
    localparam int DEF_PULSE_CYCLES = 2;

    // Pulse down-counter width; 4 bits covers pulse lengths 1..15.
    localparam int CNT_W            = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Update sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Clamp a requested pulse length to 1..15 so that a bad parameter can
    // never load zero (which would never expire) or wrap the counter.
    function automatic cnt_t pulse_load(input int cycles);
        cnt_t val;
        if (cycles < 1) begin
            val = cnt_t'(1);
        end else if (cycles > 15) begin
            val = cnt_t'(15);
        end else begin
            val = cnt_t'(cycles);
        end
        return val;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Pulse-width down-counter for the SR command generator.
// A load presets the count; while count is high it decrements once per
// cycle. expire is high during the last counted cycle, so a load of N
// gives exactly N counted cycles before expire has been seen.
module sr_pulse_timer
    import sr_cmd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cnt_t load_val,
    input  logic count,
    output logic expire
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Next count: a load wins, otherwise decrement while counting and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    // Counter register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count && (cnt_q == cnt_t'(1));

endmodule

// File: rtl/sr_cmd_gen.sv
// SR flip-flop bank command generator.
// Accepts a target word and compares it with a shadow copy of the bank.
// Bits that must rise get a set pulse and bits that must fall get a reset
// pulse; both are held for PULSE_CYCLES cycles. One quiet SETTLE cycle
// follows, then a one-cycle CHECK that pulses done and updates the shadow.
// A set bit and a reset bit can never both be asserted, because a bit is
// in set_mask only if it is 1 in the target and 0 in the shadow, and in
// clr_mask only if the reverse holds.
//
// Build option SR_CMD_GEN_VERIFY_EN: when defined, CHECK compares the bank
// readback q_fb with the target (err) and reloads the shadow from q_fb.
// When undefined, err is always 0, q_fb is ignored, and the shadow takes
// the target.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err
);

    localparam cnt_t PULSE_LOAD = pulse_load(PULSE_CYCLES);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] set_mask_q;
    logic [WIDTH-1:0] set_mask_d;
    logic [WIDTH-1:0] clr_mask_q;
    logic [WIDTH-1:0] clr_mask_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    logic [WIDTH-1:0] req_set;
    logic [WIDTH-1:0] req_clr;
    logic             req_change;
    logic             accept;
    logic             timer_load;
    logic             timer_count;
    logic             timer_expire;
    logic             check_err;
    logic [WIDTH-1:0] shadow_src;

    // Per-bit edge detection between the offered word and the shadow.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign req_set[gi] =  req_data[gi] & ~shadow_q[gi];
            assign req_clr[gi] = ~req_data[gi] &  shadow_q[gi];
        end
    endgenerate

    assign req_change = |(req_set | req_clr);
    assign accept     = req_valid && req_ready;

`ifdef SR_CMD_GEN_VERIFY_EN
    // Readback compare, and resynchronise the shadow to the real bank.
    assign check_err  = (q_fb != target_q);
    assign shadow_src = q_fb;
`else
    // Readback is not used in this build; fold it into a sink signal.
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign check_err   = 1'b0;
    assign shadow_src  = target_q;
`endif

    // Pulse length timer: loaded on a changing accept, counts through DRIVE.
    assign timer_load  = accept && req_change;
    assign timer_count = (state_q == DRIVE);

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (PULSE_LOAD),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    // State register, forced to IDLE immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the update sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = req_change ? DRIVE : CHECK;
                end
            end
            DRIVE: begin
                if (timer_expire) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic decoded from the current state.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        done      = (state_q == CHECK);
        err       = (state_q == CHECK) && check_err;
    end

    // Datapath next values: latch the request, update the shadow in CHECK,
    // and register s/r so they are asserted exactly while the FSM is in DRIVE.
    always_comb begin
        target_d   = target_q;
        set_mask_d = set_mask_q;
        clr_mask_d = clr_mask_q;
        shadow_d   = shadow_q;
        if (accept) begin
            target_d   = req_data;
            set_mask_d = req_set;
            clr_mask_d = req_clr;
        end
        if (state_q == CHECK) begin
            shadow_d = shadow_src;
        end
        s_d = (state_d == DRIVE) ? set_mask_d : '0;
        r_d = (state_d == DRIVE) ? clr_mask_d : '0;
    end

    // Datapath registers; reset drops s/r at once and forgets the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q   <= '0;
            set_mask_q <= '0;
            clr_mask_q <= '0;
            shadow_q   <= '0;
            s_q        <= '0;
            r_q        <= '0;
        end else begin
            target_q   <= target_d;
            set_mask_q <= set_mask_d;
            clr_mask_q <= clr_mask_d;
            shadow_q   <= shadow_d;
            s_q        <= s_d;
            r_q        <= r_d;
        end
    end

    assign s = s_q;
    assign r = r_q;

endmodule
